// File: rtl/psram_resp_pkg.sv
// Shared opcodes and FSM state encoding for the QSPI PSRAM responder.
package psram_resp_pkg;

   localparam logic [7:0] CMD_QREAD  = 8'hEB;
   localparam logic [7:0] CMD_QWRITE = 8'h38;
   localparam logic [7:0] CMD_QPI_EN = 8'h35;
   localparam logic [7:0] CMD_QPI_EX = 8'hF5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WAIT,
      ST_RDATA,
      ST_WDATA,
      ST_IGNORE
   } state_e;

endpackage

// File: rtl/psram_resp_sync.sv
// Two-flop synchronizer for the PSRAM pins plus sck/ce_n edge pulses in the clk domain.
module psram_resp_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       ce_n,
   input  logic [3:0] din,
   output logic       sck_rise,
   output logic       sck_fall,
   output logic       ce_n_s,
   output logic       ce_fall,
   output logic       ce_rise,
   output logic [3:0] din_s
);

   logic [5:0] meta_q, meta_d;
   logic [5:0] sync_q, sync_d;
   logic [1:0] prev_q, prev_d;

   always_comb begin
      meta_d = {sck, ce_n, din};
      sync_d = meta_q;
      prev_d = sync_q[5:4];
   end

   // ce_n resets low on purpose: a bus already selected across reset shows no
   // falling edge, so the controller has to deselect and reselect to restart.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign ce_n_s   = sync_q[4];
   assign din_s    = sync_q[3:0];
   assign sck_rise = sync_q[5] & ~prev_q[1] & ~sync_q[4];
   assign sck_fall = ~sync_q[5] & prev_q[1] & ~sync_q[4];
   assign ce_fall  = ~sync_q[4] & prev_q[0];
   assign ce_rise  = sync_q[4] & ~prev_q[0];

endmodule

// File: rtl/qspi_psram_responder.sv
// QSPI PSRAM device emulator: quad read (EB) / quad write (38) from an on-chip byte array.
// Optional QPI command mode (35 enter / F5 exit) is built when PSRAM_RESP_QPI_EN is defined.
//
// state  | meaning
// IDLE   | deselected, waiting for ce_n falling edge
// CMD    | shifting in opcode (8 serial bits, or 2 nibbles in QPI mode)
// ADDR   | shifting in 6 address nibbles
// WAIT   | counting read latency rises before first data nibble
// RDATA  | driving read nibbles on each sck fall
// WDATA  | capturing write nibbles on each sck rise
// IGNORE | opcode done or unsupported, bus stays released until deselect
module qspi_psram_responder
   import psram_resp_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 8,
   parameter int AW          = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          psram_sck,
   input  logic          psram_ce_n,
   input  logic [3:0]    psram_din,
   output logic [3:0]    psram_dout,
   output logic [3:0]    psram_douten,
   input  logic          bd_we,
   input  logic [AW-1:0] bd_addr,
   input  logic [7:0]    bd_wdata,
   output logic [7:0]    bd_rdata,
   output logic          busy,
   output logic          cmd_err
);

   logic       sck_rise, sck_fall, ce_n_s, ce_fall, ce_rise;
   logic [3:0] din_s;

   psram_resp_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .sck      (psram_sck),
      .ce_n     (psram_ce_n),
      .din      (psram_din),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .ce_n_s   (ce_n_s),
      .ce_fall  (ce_fall),
      .ce_rise  (ce_rise),
      .din_s    (din_s)
   );

   state_e        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    op_q, op_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    wait_cnt_q, wait_cnt_d;
   logic          nib_hi_q, nib_hi_d;
   logic          is_rd_q, is_rd_d;
   logic [3:0]    wr_hi_q, wr_hi_d;
   logic [3:0]    dout_q, dout_d;
   logic [3:0]    douten_q, douten_d;
   logic          busy_q, busy_d;
   logic          cmd_err_q, cmd_err_d;
   logic [7:0]    bd_rdata_q, bd_rdata_d;
   logic          qpi_mode;
   logic          bus_we;
   logic [7:0]    rd_byte;

   logic [7:0] mem [DEPTH];

   assign rd_byte = mem[addr_q];

`ifdef PSRAM_RESP_QPI_EN
   logic qpi_q, qpi_d;
   assign qpi_mode = qpi_q;
`else
   assign qpi_mode = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wait_cnt_d = wait_cnt_q;
      nib_hi_d   = nib_hi_q;
      is_rd_d    = is_rd_q;
      wr_hi_d    = wr_hi_q;
      dout_d     = dout_q;
      cmd_err_d  = cmd_err_q;
      bus_we     = 1'b0;
`ifdef PSRAM_RESP_QPI_EN
      qpi_d      = qpi_q;
`endif
      if (ce_n_s || ce_rise) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ce_fall) begin
                  state_d   = ST_CMD;
                  bit_cnt_d = '0;
               end
            end
            ST_CMD: begin
               if (sck_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (qpi_mode) begin
                     if (bit_cnt_q[0]) op_d[3:0] = din_s;
                     else              op_d[7:4] = din_s;
                  end else begin
                     op_d[3'd7 - bit_cnt_q] = din_s[0];
                  end
                  if (bit_cnt_q == (qpi_mode ? 3'd1 : 3'd7)) begin
                     bit_cnt_d = '0;
                     state_d   = ST_IGNORE;
                     case (op_d)
                        CMD_QREAD: begin
                           state_d = ST_ADDR;
                           is_rd_d = 1'b1;
                        end
                        CMD_QWRITE: begin
                           state_d = ST_ADDR;
                           is_rd_d = 1'b0;
                        end
`ifdef PSRAM_RESP_QPI_EN
                        CMD_QPI_EN: qpi_d = 1'b1;
                        CMD_QPI_EX: qpi_d = 1'b0;
`endif
                        default:    cmd_err_d = 1'b1;
                     endcase
                  end
               end
            end
            ST_ADDR: begin
               if (sck_rise) begin
                  // Only the low AW bits survive the shift; upper address bits fall off.
                  addr_d    = {addr_q[AW-5:0], din_s};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd5) begin
                     nib_hi_d = 1'b1;
                     if (is_rd_q) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = 8'(WAIT_CYCLES);
                     end else begin
                        state_d = ST_WDATA;
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (sck_rise && wait_cnt_q != 8'd0) begin
                  wait_cnt_d = wait_cnt_q - 8'd1;
               end else if (sck_fall && wait_cnt_q == 8'd0) begin
                  dout_d   = rd_byte[7:4];
                  nib_hi_d = 1'b0;
                  state_d  = ST_RDATA;
               end
            end
            ST_RDATA: begin
               if (sck_fall) begin
                  if (nib_hi_q) begin
                     dout_d   = rd_byte[7:4];
                     nib_hi_d = 1'b0;
                  end else begin
                     dout_d   = rd_byte[3:0];
                     addr_d   = addr_q + AW'(1);
                     nib_hi_d = 1'b1;
                  end
               end
            end
            ST_WDATA: begin
               if (sck_rise) begin
                  if (nib_hi_q) begin
                     wr_hi_d  = din_s;
                     nib_hi_d = 1'b0;
                  end else begin
                     bus_we   = 1'b1;
                     addr_d   = addr_q + AW'(1);
                     nib_hi_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
      douten_d   = (state_d == ST_RDATA) ? 4'hF : 4'h0;
      busy_d     = (state_d != ST_IDLE);
      bd_rdata_d = mem[bd_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         op_q       <= '0;
         addr_q     <= '0;
         wait_cnt_q <= '0;
         nib_hi_q   <= 1'b0;
         is_rd_q    <= 1'b0;
         wr_hi_q    <= '0;
         dout_q     <= '0;
         douten_q   <= '0;
         busy_q     <= 1'b0;
         cmd_err_q  <= 1'b0;
         bd_rdata_q <= '0;
`ifdef PSRAM_RESP_QPI_EN
         qpi_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wait_cnt_q <= wait_cnt_d;
         nib_hi_q   <= nib_hi_d;
         is_rd_q    <= is_rd_d;
         wr_hi_q    <= wr_hi_d;
         dout_q     <= dout_d;
         douten_q   <= douten_d;
         busy_q     <= busy_d;
         cmd_err_q  <= cmd_err_d;
         bd_rdata_q <= bd_rdata_d;
`ifdef PSRAM_RESP_QPI_EN
         qpi_q      <= qpi_d;
`endif
      end
   end

   // Single write port: a bus byte takes priority over a same-cycle backdoor write.
   always_ff @(posedge clk) begin
      if (bus_we && !rst)
         mem[addr_q] <= {wr_hi_q, din_s};
      else if (bd_we)
         mem[bd_addr] <= bd_wdata;
   end

   assign psram_dout   = dout_q;
   assign psram_douten = douten_q;
   assign busy         = busy_q;
   assign cmd_err      = cmd_err_q;
   assign bd_rdata     = bd_rdata_q;

endmodule

// File: tb/tb_qspi_psram_responder.sv
// Self-checking bench for qspi_psram_responder: bus-level model of the PSRAM byte array
// with directed scenarios followed by randomized quad read/write transactions.
module tb_qspi_psram_responder;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;
   localparam int WAITC = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          psram_sck = 1'b0;
   logic          psram_ce_n = 1'b1;
   logic [3:0]    psram_din = 4'h0;
   logic [3:0]    psram_dout;
   logic [3:0]    psram_douten;
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [7:0]    bd_wdata = 8'h00;
   logic [7:0]    bd_rdata;
   logic          busy;
   logic          cmd_err;

   always #5 clk = ~clk;

   qspi_psram_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC), .AW(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .psram_sck    (psram_sck),
      .psram_ce_n   (psram_ce_n),
      .psram_din    (psram_din),
      .psram_dout   (psram_dout),
      .psram_douten (psram_douten),
      .bd_we        (bd_we),
      .bd_addr      (bd_addr),
      .bd_wdata     (bd_wdata),
      .bd_rdata     (bd_rdata),
      .busy         (busy),
      .cmd_err      (cmd_err)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] mem_m [DEPTH];
   logic [3:0] e_douten = 4'h0, e_dout = 4'h0, n_douten = 4'h0, n_dout = 4'h0;
   logic       e_busy = 1'b0, n_busy = 1'b0, e_err = 1'b0, n_err = 1'b0;
   logic       chk_en = 1'b0;
   logic       m_qpi = 1'b0;
   logic [3:0] cap_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("douten", 32'(psram_douten), 32'(e_douten));
         check("busy", 32'(busy), 32'(e_busy));
         check("cmd_err", 32'(cmd_err), 32'(e_err));
         if (e_douten == 4'hF) check("dout", 32'(psram_dout), 32'(e_dout));
      end
   end

   function automatic logic [3:0] exp_nib(input int m, input int k);
      logic [7:0] b;
      b = mem_m[(m + k / 2) % DEPTH];
      return (k % 2 == 0) ? b[7:4] : b[3:0];
   endfunction

   function automatic bit op_known(input logic [7:0] op);
      bit k;
      k = (op == 8'hEB) || (op == 8'h38);
`ifdef PSRAM_RESP_QPI_EN
      k = k || (op == 8'h35) || (op == 8'hF5);
`endif
      return k;
   endfunction

   task automatic align();
      @(negedge clk);
      #3;
   endtask

   // Move a pin, then after the synchronizer latency publish the staged expectations.
   task automatic pin(input logic s, input logic c);
      psram_sck  = s;
      psram_ce_n = c;
      chk_en     = 1'b0;
      #50;
      e_douten = n_douten;
      e_dout   = n_dout;
      e_busy   = n_busy;
      e_err    = n_err;
      chk_en   = 1'b1;
      #30;
   endtask

   task automatic cycle(input logic [3:0] d);
      psram_din = d;
      #30;
      pin(1'b1, psram_ce_n);
      pin(1'b0, psram_ce_n);
   endtask

   task automatic ce_start();
      align();
      n_busy   = 1'b1;
      n_douten = 4'h0;
      pin(1'b0, 1'b0);
   endtask

   task automatic ce_end();
      n_busy   = 1'b0;
      n_douten = 4'h0;
      pin(1'b0, 1'b1);
      #80;
   endtask

   task automatic send_cmd(input logic [7:0] op);
      if (m_qpi) begin
         for (int i = 0; i < 2; i++) begin
            if (i == 1 && !op_known(op)) n_err = 1'b1;
            cycle(i == 0 ? op[7:4] : op[3:0]);
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (i == 7 && !op_known(op)) n_err = 1'b1;
            cycle({3'($urandom), op[7-i]});
         end
      end
`ifdef PSRAM_RESP_QPI_EN
      if (op == 8'h35) m_qpi = 1'b1;
      if (op == 8'hF5) m_qpi = 1'b0;
`endif
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 0; i < 6; i++) cycle(a[23-4*i -: 4]);
   endtask

   task automatic rd_data(input logic [23:0] a, input int nn);
      int m;
      m = int'(a[AW-1:0]);
      for (int i = 0; i < WAITC; i++) begin
         psram_din = 4'($urandom);
         #30;
         pin(1'b1, 1'b0);
         if (i == WAITC - 1) begin
            n_douten = 4'hF;
            n_dout   = exp_nib(m, 0);
         end
         pin(1'b0, 1'b0);
      end
      cap_q.push_back(psram_dout);
      for (int k = 1; k < nn; k++) begin
         #30;
         pin(1'b1, 1'b0);
         n_dout = exp_nib(m, k);
         pin(1'b0, 1'b0);
         cap_q.push_back(psram_dout);
      end
   endtask

   task automatic rd_txn(input logic [23:0] a, input int nn);
      ce_start();
      send_cmd(8'hEB);
      send_addr(a);
      rd_data(a, nn);
      ce_end();
   endtask

   task automatic bd_check(input string name, input int a);
      @(negedge clk);
      bd_addr = a[AW-1:0];
      @(negedge clk);
      check(name, 32'(bd_rdata), 32'(mem_m[a]));
   endtask

   task automatic wr_txn(input logic [23:0] a, input logic [3:0] wq [$]);
      int m;
      m = int'(a[AW-1:0]);
      ce_start();
      send_cmd(8'h38);
      send_addr(a);
      for (int k = 0; k < wq.size(); k++) begin
         cycle(wq[k]);
         if (k % 2 == 1) mem_m[(m + k / 2) % DEPTH] = {wq[k-1], wq[k]};
      end
      ce_end();
      for (int k = 0; k <= wq.size() / 2; k++) bd_check("wr_bd", (m + k) % DEPTH);
   endtask

   task automatic bd_write(input int a, input logic [7:0] d);
      @(negedge clk);
      bd_we    = 1'b1;
      bd_addr  = a[AW-1:0];
      bd_wdata = d;
      mem_m[a] = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   logic [3:0] lit [8];
   logic [3:0] wq [$];
   logic [7:0] old_b;
   int         t_addr;

   initial begin
      lit = '{4'hA, 4'h1, 4'hB, 4'h2, 4'hC, 4'h3, 4'hD, 4'h4};
      repeat (4) @(negedge clk);
      check("rst_douten", 32'(psram_douten), 32'h0);
      check("rst_dout", 32'(psram_dout), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_cmd_err", 32'(cmd_err), 32'h0);
      check("rst_bd_rdata", 32'(bd_rdata), 32'h0);
      rst = 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         bd_we    = 1'b1;
         bd_addr  = i[AW-1:0];
         bd_wdata = 8'($urandom);
         mem_m[i] = bd_wdata;
      end
      @(negedge clk);
      bd_we = 1'b0;

      // Test 1: backdoor preload then quad read of 4 bytes.
      bd_write(16'h10, 8'hA1);
      bd_write(16'h11, 8'hB2);
      bd_write(16'h12, 8'hC3);
      bd_write(16'h13, 8'hD4);
      for (int k = 0; k < 8; k++) check("model_nib", 32'(exp_nib(16, k)), 32'(lit[k]));
      cap_q.delete();
      rd_txn(24'h000010, 8);
      check("t1_len", cap_q.size(), 8);
      for (int k = 0; k < 8 && k < cap_q.size(); k++) check("t1_nib", 32'(cap_q[k]), 32'(lit[k]));

      // Test 2: write across the top of memory wraps to 0.
      wq = '{4'h5, 4'hA, 4'h6, 4'hB};
      wr_txn(24'h0003FF, wq);
      bd_addr = 10'h3FF;
      @(negedge clk);
      @(negedge clk);
      check("t2_3ff", 32'(bd_rdata), 32'h5A);
      bd_addr = 10'h000;
      @(negedge clk);
      @(negedge clk);
      check("t2_000", 32'(bd_rdata), 32'h6B);
      cap_q.delete();
      rd_txn(24'hABC3FF, 4);
      for (int k = 0; k < 4 && k < cap_q.size(); k++) check("t2_rd_wrap", 32'(cap_q[k]), 32'(wq[k]));

      // Test 3: partial write byte is dropped.
      t_addr = $urandom_range(32, 1000);
      old_b  = mem_m[t_addr];
      wq = '{4'h7};
      wr_txn(24'(t_addr), wq);
      bd_addr = t_addr[AW-1:0];
      @(negedge clk);
      @(negedge clk);
      check("t3_unchanged", 32'(bd_rdata), 32'(old_b));

      // Test 4: unsupported opcode sets sticky cmd_err, then a normal read.
      ce_start();
      send_cmd(8'h9F);
      for (int i = 0; i < 3; i++) cycle(4'($urandom));
      ce_end();
      check("t4_err", 32'(cmd_err), 32'h1);
      rd_txn(24'($urandom), 6);

      // Test 5: reset in the middle of read data.
      t_addr = $urandom_range(0, DEPTH - 1);
      ce_start();
      send_cmd(8'hEB);
      send_addr(24'(t_addr));
      rd_data(24'(t_addr), 3);
      chk_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t5_douten", 32'(psram_douten), 32'h0);
      check("t5_busy", 32'(busy), 32'h0);
      check("t5_err", 32'(cmd_err), 32'h0);
      rst = 1'b0;
      n_douten = 4'h0;
      n_busy   = 1'b0;
      n_err    = 1'b0;
      e_douten = 4'h0;
      e_busy   = 1'b0;
      e_err    = 1'b0;
      m_qpi    = 1'b0;
      align();
      for (int i = 0; i < 3; i++) cycle(4'($urandom));
      ce_end();
      rd_txn(24'(t_addr), 6);

`ifdef PSRAM_RESP_QPI_EN
      // Test 6: QPI command mode entry/exit.
      ce_start();
      send_cmd(8'h35);
      ce_end();
      cap_q.delete();
      rd_txn(24'h000010, 8);
      for (int k = 0; k < 8 && k < cap_q.size(); k++) check("t6_nib", 32'(cap_q[k]), 32'(lit[k]));
      ce_start();
      send_cmd(8'hF5);
      ce_end();
      rd_txn(24'h000012, 4);
`endif

      // Randomized traffic, biased toward the wrap boundary.
      for (int r = 0; r < 10; r++) begin
         logic [23:0] a;
         int          nn;
         a  = 24'($urandom);
         if (r % 3 == 0) a[AW-1:0] = 10'(DEPTH - 1 - $urandom_range(0, 3));
         nn = $urandom_range(1, 9);
         if ($urandom_range(0, 1) == 1) begin
            rd_txn(a, nn);
         end else begin
            wq.delete();
            for (int k = 0; k < nn; k++) wq.push_back(4'($urandom));
            wr_txn(a, wq);
         end
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
